// File: rtl/dac_segment_encoder.sv
// dac_segment_encoder: front stage of the segmented current-steering DAC.
// Splits a 12-bit unsigned sample into NBIN binary LSB controls and NTHERM
// unary MSB controls (plus complements), saturating at full scale, through a
// two-stage registered pipeline. A small FSM sequences the driver pdb line so
// the cells only ever switch while powered: zero code during wake-up and drain.
//
// Optional build macro: DAC_SEG_DEM_EN
//   defined   -> data-weighted averaging: a rotating pointer selects which
//                unary elements carry the m ones.
//   undefined -> fixed thermometer mapping, no pointer register.
//
// State table
//   state     | meaning
//   ST_OFF    | driver powered down (pdb=0), code forced to zero
//   ST_WAKE   | pdb=1, zero code while the driver settles for WAKE_CYC cycles
//   ST_ACTIVE | ready=1, samples flow through the pipeline
//   ST_DRAIN  | pdb=1, zero code for DRAIN_CYC cycles before powering down
module dac_segment_encoder #(
  parameter int NBIN      = 7,
  parameter int NTHERM    = 17,
  parameter int CODE_W    = 12,
  parameter int WAKE_CYC  = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              ready,
  output logic              sat,
  output logic [NBIN-1:0]   datain,
  output logic [NBIN-1:0]   datainb,
  output logic [NTHERM-1:0] datatherm,
  output logic [NTHERM-1:0] datathermb,
  output logic              pdb
);

  localparam int FS    = NTHERM * (1 << NBIN) + (1 << NBIN) - 1;
  localparam int M_W   = CODE_W - NBIN;
  localparam int CNT_MAX = (WAKE_CYC > DRAIN_CYC) ? WAKE_CYC : DRAIN_CYC;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CODE_W-1:0]  s1_code;
  logic [CODE_W-1:0]  code_sat;
  logic               over_fs;
  logic               accept;
  logic [M_W-1:0]     m_s1;
  logic [NTHERM-1:0]  therm_nxt;

  // Clamp the incoming sample to full scale; accept only while ACTIVE and enabled.
  always_comb begin
    over_fs  = (code_in > CODE_W'(FS));
    code_sat = over_fs ? CODE_W'(FS) : code_in;
    accept   = (state == ST_ACTIVE) && en && code_valid;
  end

  // Power sequencing FSM with registered pdb/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      cnt   <= '0;
      pdb   <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (en) begin
            state <= ST_WAKE;
            cnt   <= '0;
            pdb   <= 1'b1;
          end
        end
        ST_WAKE: begin
          if (!en) begin
            state <= ST_OFF;
            pdb   <= 1'b0;
          end else if (cnt == CNT_W'(WAKE_CYC - 1)) begin
            state <= ST_ACTIVE;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!en) begin
            state <= ST_DRAIN;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // en is deliberately ignored here; a drain always completes
          if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
            state <= ST_OFF;
            pdb   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
          pdb   <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the clamped sample and saturation flag, or force zero outside ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_code <= '0;
      sat     <= 1'b0;
    end else if (state != ST_ACTIVE || !en) begin
      s1_code <= '0;
    end else if (accept) begin
      s1_code <= code_sat;
      sat     <= over_fs;
    end
  end

  assign m_s1 = s1_code[CODE_W-1:NBIN];

`ifdef DAC_SEG_DEM_EN
  localparam int PTR_W = $clog2(NTHERM);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] s1_ptr;
  logic [PTR_W:0]   ptr_sum;
  logic [PTR_W-1:0] ptr_nxt;
  logic             off_entry;

  // Next rotation pointer: advance by the accepted sample's unary count, modulo NTHERM.
  always_comb begin
    ptr_sum   = {1'b0, ptr} + (PTR_W + 1)'(code_sat[CODE_W-1:NBIN]);
    ptr_nxt   = (ptr_sum >= (PTR_W + 1)'(NTHERM)) ?
                PTR_W'(ptr_sum - (PTR_W + 1)'(NTHERM)) : PTR_W'(ptr_sum);
    off_entry = ((state == ST_WAKE) && !en) ||
                ((state == ST_DRAIN) && (cnt == CNT_W'(DRAIN_CYC - 1)));
  end

  // Rotation pointer; the start index for each sample travels with it in stage 1.
  always_ff @(posedge clk) begin
    if (rst || off_entry) begin
      ptr    <= '0;
      s1_ptr <= '0;
    end else if (accept) begin
      ptr    <= ptr_nxt;
      s1_ptr <= ptr;
    end
  end

  // Select m consecutive elements starting at the sample's pointer, wrapping at NTHERM.
  always_comb begin
    therm_nxt = '0;
    for (int i = 0; i < NTHERM; i++) begin
      int off;
      off = i - int'(s1_ptr);
      if (off < 0) off = off + NTHERM;
      therm_nxt[i] = (off < int'(m_s1));
    end
  end
`else
  // Fixed thermometer: the lowest m elements are on.
  always_comb begin
    therm_nxt = '0;
    for (int i = 0; i < NTHERM; i++) begin
      therm_nxt[i] = (M_W'(i) < m_s1);
    end
  end
`endif

  // Stage 2: registered driver controls; they hold while stage 1 holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      datain    <= '0;
      datatherm <= '0;
    end else begin
      datain    <= s1_code[NBIN-1:0];
      datatherm <= therm_nxt;
    end
  end

  assign datainb    = ~datain;
  assign datathermb = ~datatherm;

endmodule
